// File: rtl/lvds_tx.sv
// LVDS frame transmitter: buffers EU words, then streams one frame MSB first under an
// active-low LVDS_VS strobe with a free-running forwarded bit clock.
module lvds_tx #(
  parameter int CLK_DIV  = 2,
  parameter int GAP_BITS = 4,
  parameter int ADDR_W   = 9
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [31:0]       EU_LVDS_TX_BUF_WDATA,
  input  logic [ADDR_W-1:0] EU_LVDS_TX_BUF_ADDR,
  input  logic              EU_LVDS_TX_BUF_WEN,
  input  logic [ADDR_W:0]   LVDS_TX_LEN,
  input  logic              LVDS_TX_START_CS,
  input  logic              LVDS_TX_START,
  input  logic              LVDS_STATE_CLEAR_CS,
  input  logic              LVDS_STATE_CLEAR,
  output logic [7:0]        LVDS_TX_EU_STATE,
  output logic              LVDS_VS,
  output logic              LVDS_CLK,
  output logic              LVDS_DATA
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (GAP_BITS > 0) ? $clog2(GAP_BITS + 1) : 1;
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT_TICK, S_SHIFT, S_GAP} state_t;

  logic [31:0]       mem [0:(1<<ADDR_W)-1];
  logic [31:0]       rd_data_q;
  logic [ADDR_W-1:0] rd_addr;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [31:0]       shift_q, shift_d;
  logic [31:0]       pref_q, pref_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic              lvds_clk_q, lvds_clk_d;
  logic              vs_q, vs_d;
  logic              data_q, data_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              div_wrap, tick;
  logic              start_eff, clear_eff, len_ok, more_words;
  logic              set_done, set_err;
  logic [ADDR_W:0]   next_word;

  // Buffer: EU writes at any time; reads are registered (one cycle latency).
  always_ff @(posedge CLK) begin
    if (EU_LVDS_TX_BUF_WEN) begin
      mem[EU_LVDS_TX_BUF_ADDR] <= EU_LVDS_TX_BUF_WDATA;
    end
    rd_data_q <= mem[rd_addr];
  end

  // Bit tick is the CLK edge that drives LVDS_CLK low.
  always_comb begin
    div_wrap   = (div_cnt_q == DIV_W'(CLK_DIV - 1));
    div_cnt_d  = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
    lvds_clk_d = div_wrap ? ~lvds_clk_q : lvds_clk_q;
    tick       = div_wrap & lvds_clk_q;
  end

  always_comb begin
    start_eff  = LVDS_TX_START_CS & LVDS_TX_START;
    clear_eff  = LVDS_STATE_CLEAR_CS & LVDS_STATE_CLEAR;
    len_ok     = (LVDS_TX_LEN != '0) && (LVDS_TX_LEN <= DEPTH);
    next_word  = {1'b0, word_idx_q} + (ADDR_W+1)'(1);
    more_words = (next_word < len_q);

    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    pref_d     = pref_q;
    gap_cnt_d  = gap_cnt_q;
    vs_d       = vs_q;
    data_d     = data_q;
    rd_addr    = word_idx_q;
    set_done   = 1'b0;
    set_err    = (start_eff && state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start_eff) begin
          if (len_ok) begin
            len_d      = LVDS_TX_LEN;
            word_idx_d = '0;
            bit_cnt_d  = '0;
            state_d    = S_FETCH;
          end else begin
            set_err = 1'b1;
          end
        end
      end
      S_FETCH: begin
        state_d = S_WAIT_TICK;
      end
      S_WAIT_TICK: begin
        if (tick) begin
          shift_d   = rd_data_q;
          vs_d      = 1'b0;
          data_d    = rd_data_q[31];
          bit_cnt_d = 6'd1;
          state_d   = S_SHIFT;
        end
      end
      S_SHIFT: begin
        // Next word is read during the current one and frozen for its last bit period.
        rd_addr = next_word[ADDR_W-1:0];
        if (bit_cnt_q < 6'd32) begin
          pref_d = rd_data_q;
        end
        if (tick) begin
          if (bit_cnt_q != 6'd32) begin
            shift_d   = {shift_q[30:0], 1'b0};
            data_d    = shift_q[30];
            bit_cnt_d = bit_cnt_q + 6'd1;
          end else if (more_words) begin
            shift_d    = pref_q;
            data_d     = pref_q[31];
            bit_cnt_d  = 6'd1;
            word_idx_d = next_word[ADDR_W-1:0];
          end else begin
            vs_d      = 1'b1;
            data_d    = 1'b0;
            gap_cnt_d = '0;
            state_d   = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          if (gap_cnt_q == GAP_W'(GAP_BITS)) begin
            set_done = 1'b1;
            state_d  = S_IDLE;
          end else begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A status set in the same cycle as a clear takes precedence.
    done_d = clear_eff ? 1'b0 : done_q;
    err_d  = clear_eff ? 1'b0 : err_q;
    if (set_done) done_d = 1'b1;
    if (set_err)  err_d  = 1'b1;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      pref_q     <= '0;
      gap_cnt_q  <= '0;
      div_cnt_q  <= '0;
      lvds_clk_q <= 1'b1;
      vs_q       <= 1'b1;
      data_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      pref_q     <= pref_d;
      gap_cnt_q  <= gap_cnt_d;
      div_cnt_q  <= div_cnt_d;
      lvds_clk_q <= lvds_clk_d;
      vs_q       <= vs_d;
      data_q     <= data_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign LVDS_TX_EU_STATE = {5'b0, err_q, done_q, (state_q != S_IDLE)};
  assign LVDS_VS          = vs_q;
  assign LVDS_CLK         = lvds_clk_q;
  assign LVDS_DATA        = data_q;

endmodule
